// File: rtl/pe_rs_core.sv
// Row-stationary PE: loads a filter row for FILTER_NUM kernels into a filter
// scratchpad, streams an ifmap row through a circular scratchpad, and emits
// one FILTER_NUM-lane output psum per ofmap pixel.
//
// Handshake: every channel moves one item at a posedge where enable, valid
// (the *_enable input, or opsum_enable for the output) and ready are all 1.
// Ready outputs depend only on registered state and enable, never on valid.
module pe_rs_core #(
    parameter int IFMAP_SPAD_SIZE  = 12,
    parameter int FILTER_SPAD_SIZE = 224,
    parameter int IFMAP_DATA_SIZE  = 8,
    parameter int FILTER_DATA_SIZE = 8,
    parameter int PSUM_DATA_SIZE   = 16,
    parameter int FILTER_NUM       = 4,
    parameter int MA_X             = 0,
    parameter int MA_Y             = 0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 enable,
    input  logic                                 set_info,
    input  logic                                 keep_filter,
    input  logic [1:0]                           config_q,
    input  logic [3:0]                           config_S,
    input  logic [3:0]                           config_U,
    input  logic [7:0]                           config_F,
    input  logic [FILTER_NUM*FILTER_DATA_SIZE-1:0] filter,
    input  logic                                 filter_enable,
    output logic                                 filter_ready,
    input  logic [IFMAP_DATA_SIZE-1:0]           ifmap,
    input  logic                                 ifmap_enable,
    output logic                                 ifmap_ready,
    input  logic [FILTER_NUM*PSUM_DATA_SIZE-1:0] ipsum,
    input  logic                                 ipsum_enable,
    output logic                                 ipsum_ready,
    output logic [FILTER_NUM*PSUM_DATA_SIZE-1:0] opsum,
    output logic                                 opsum_enable,
    input  logic                                 opsum_ready,
    output logic                                 busy,
    output logic                                 cfg_err,
    output logic [2:0]                           dbg_state,
    output logic [15:0]                          dbg_pos
);

    localparam int FD      = FILTER_DATA_SIZE;
    localparam int ID      = IFMAP_DATA_SIZE;
    localparam int P       = PSUM_DATA_SIZE;
    localparam int W_DEPTH = FILTER_SPAD_SIZE / FILTER_NUM;
    localparam int IW      = $clog2(IFMAP_SPAD_SIZE);
    localparam int FW      = $clog2(W_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_FILL, S_MAC, S_IPSUM, S_OUT, S_SHIFT
    } state_t;

    state_t                  state_q;
    logic [7:0]              cnt_q, head_q, n_q, uq_q, f_q, out_cnt_q;
    logic [3:0]              s_q, ld_s_q;
    logic [2:0]              q_q, ld_q_q;
    logic                    loaded_q, cfg_err_q;
    logic [FILTER_NUM*P-1:0] acc_q, opsum_q;

    // Scratchpads carry no reset: contents survive reset, only the loaded flag is cleared.
    logic [ID-1:0]            ifmap_spad  [IFMAP_SPAD_SIZE];
    logic [FILTER_NUM*FD-1:0] filter_spad [W_DEPTH];

    logic xfer_f, xfer_i, xfer_p, xfer_o;
    assign filter_ready = enable && (state_q == S_LOAD);
    assign ifmap_ready  = enable && ((state_q == S_FILL) || (state_q == S_SHIFT));
    assign ipsum_ready  = enable && (state_q == S_IPSUM);
    assign opsum_enable = enable && (state_q == S_OUT);
    assign xfer_f = filter_ready && filter_enable;
    assign xfer_i = ifmap_ready && ifmap_enable;
    assign xfer_p = ipsum_ready && ipsum_enable;
    assign xfer_o = opsum_enable && opsum_ready;

    assign opsum     = opsum_q;
    assign busy      = (state_q != S_IDLE);
    assign cfg_err   = cfg_err_q;
    assign dbg_state = state_q;
    assign dbg_pos   = {8'(MA_X), 8'(MA_Y)};

    // Incoming configuration, decoded and checked combinationally.
    logic [2:0] cq;
    logic [7:0] n_cfg, uq_cfg;
    logic       cfg_bad;
    assign cq     = {1'b0, config_q} + 3'd1;
    assign n_cfg  = 8'(config_S) * 8'(cq);
    assign uq_cfg = 8'(config_U) * 8'(cq);
    assign cfg_bad = (config_S == 4'd0) || (config_U == 4'd0) || (config_F == 8'd0)
                  || (config_U > config_S)
                  || (int'(n_cfg) > IFMAP_SPAD_SIZE)
                  || (int'(n_cfg) * FILTER_NUM > FILTER_SPAD_SIZE)
                  || (keep_filter && (!loaded_q || (ld_s_q != config_S) || (ld_q_q != cq)));

    // Circular ifmap index (head+cnt) mod N; both terms are below N so one subtract suffices.
    logic [8:0]    circ_sum, head_sum;
    logic [IW-1:0] circ_idx;
    logic [7:0]    head_adv;
    assign circ_sum = {1'b0, head_q} + {1'b0, cnt_q};
    assign circ_idx = IW'((circ_sum >= {1'b0, n_q}) ? circ_sum - {1'b0, n_q} : circ_sum);
    assign head_sum = {1'b0, head_q} + {1'b0, uq_q};
    assign head_adv = 8'((head_sum >= {1'b0, n_q}) ? head_sum - {1'b0, n_q} : head_sum);

    // Per-lane MAC step and ipsum add, wrapping at PSUM_DATA_SIZE.
    logic [ID-1:0]               if_rd;
    logic [FILTER_NUM*FD-1:0]    w_rd;
    logic signed [ID+FD-1:0]     prod;
    logic signed [P-1:0]         lane_add;
    logic [FILTER_NUM*P-1:0]     acc_mac, opsum_sum;
    always_comb begin
        acc_mac   = '0;
        opsum_sum = '0;
        prod      = '0;
        lane_add  = '0;
        if_rd     = ifmap_spad[circ_idx];
        w_rd      = filter_spad[FW'(cnt_q)];
        for (int k = 0; k < FILTER_NUM; k++) begin
            prod     = $signed(if_rd) * $signed(w_rd[k*FD +: FD]);
            lane_add = P'(prod);
            acc_mac[k*P +: P]   = (cnt_q == 8'd0) ? lane_add : acc_q[k*P +: P] + lane_add;
            opsum_sum[k*P +: P] = acc_q[k*P +: P] + ipsum[k*P +: P];
        end
    end

    // Scratchpad writes: filter words at index cnt, ifmap elements at the circular index.
    always_ff @(posedge clk) begin
        if (rst && xfer_f) filter_spad[FW'(cnt_q)] <= filter;
        if (rst && xfer_i) ifmap_spad[circ_idx] <= ifmap;
    end

    // Main FSM; enable=0 holds every register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            head_q    <= '0;
            n_q       <= '0;
            uq_q      <= '0;
            f_q       <= '0;
            out_cnt_q <= '0;
            s_q       <= '0;
            q_q       <= '0;
            ld_s_q    <= '0;
            ld_q_q    <= '0;
            loaded_q  <= 1'b0;
            cfg_err_q <= 1'b0;
            acc_q     <= '0;
            opsum_q   <= '0;
        end else if (enable) begin
            case (state_q)
                S_IDLE: if (set_info) begin
                    if (cfg_bad) begin
                        cfg_err_q <= 1'b1;
                    end else begin
                        cfg_err_q <= 1'b0;
                        s_q       <= config_S;
                        q_q       <= cq;
                        n_q       <= n_cfg;
                        uq_q      <= uq_cfg;
                        f_q       <= config_F;
                        cnt_q     <= '0;
                        head_q    <= '0;
                        out_cnt_q <= '0;
                        state_q   <= keep_filter ? S_FILL : S_LOAD;
                    end
                end
                S_LOAD: if (xfer_f) begin
                    if (cnt_q == n_q - 8'd1) begin
                        cnt_q    <= '0;
                        loaded_q <= 1'b1;
                        ld_s_q   <= s_q;
                        ld_q_q   <= q_q;
                        state_q  <= S_FILL;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                S_FILL: if (xfer_i) begin
                    if (cnt_q == n_q - 8'd1) begin
                        cnt_q   <= '0;
                        head_q  <= '0;
                        state_q <= S_MAC;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                S_MAC: begin
                    acc_q <= acc_mac;
                    if (cnt_q == n_q - 8'd1) begin
                        cnt_q   <= '0;
                        state_q <= S_IPSUM;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                S_IPSUM: if (xfer_p) begin
                    opsum_q <= opsum_sum;
                    state_q <= S_OUT;
                end
                S_OUT: if (xfer_o) begin
                    out_cnt_q <= out_cnt_q + 8'd1;
                    cnt_q     <= '0;
                    state_q   <= (out_cnt_q + 8'd1 == f_q) ? S_IDLE : S_SHIFT;
                end
                S_SHIFT: if (xfer_i) begin
                    if (cnt_q == uq_q - 8'd1) begin
                        cnt_q   <= '0;
                        head_q  <= head_adv;
                        state_q <= S_MAC;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
